// File: rtl/cu_pkg.sv
// Shared definitions for the datapath control unit.
// Holds the opcode map, the ALU operation codes, the sequencer phase encoding
// and the instruction-class enum produced by cu_decode.
package cu_pkg;

  // Opcodes, IR[31:27]
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // ALU operation codes
  localparam logic [3:0] ALU_NONE = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0101;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;

  // Fetch always runs F0..F2
  localparam logic [2:0] FETCH_LAST = 3'd2;

  typedef enum logic [1:0] {
    PH_RST   = 2'd0,
    PH_FETCH = 2'd1,
    PH_EXEC  = 2'd2,
    PH_HALT  = 2'd3
  } phase_t;

  typedef enum logic [3:0] {
    CL_RTYPE = 4'd0,
    CL_IMM   = 4'd1,
    CL_LDI   = 4'd2,
    CL_LD    = 4'd3,
    CL_ST    = 4'd4,
    CL_BR    = 4'd5,
    CL_IN    = 4'd6,
    CL_OUT   = 4'd7,
    CL_MFHI  = 4'd8,
    CL_MFLO  = 4'd9,
    CL_NOP   = 4'd10,
    CL_HALT  = 4'd11,
    CL_ILL   = 4'd12
  } iclass_t;

endpackage

// File: rtl/cu_decode.sv
// Opcode decoder for the control unit (purely combinational).
// Ports:
//   i_opcode    - IR[31:27]
//   o_class     - instruction class (iclass_t encoding)
//   o_alu_op    - ALU code used in the compute step of the class
//   o_last_step - index of the final execute step of the class
module cu_decode
  import cu_pkg::*;
(
  input  logic [4:0] i_opcode,
  output logic [3:0] o_class,
  output logic [3:0] o_alu_op,
  output logic [2:0] o_last_step
);

  always_comb begin
    o_class     = CL_ILL;
    o_alu_op    = ALU_NONE;
    o_last_step = 3'd0;
    case (i_opcode)
      OP_ADD:  begin o_class = CL_RTYPE; o_alu_op = ALU_ADD; o_last_step = 3'd2; end
      OP_SUB:  begin o_class = CL_RTYPE; o_alu_op = ALU_SUB; o_last_step = 3'd2; end
      OP_AND:  begin o_class = CL_RTYPE; o_alu_op = ALU_AND; o_last_step = 3'd2; end
      OP_OR:   begin o_class = CL_RTYPE; o_alu_op = ALU_OR;  o_last_step = 3'd2; end
      OP_ADDI: begin o_class = CL_IMM;   o_alu_op = ALU_ADD; o_last_step = 3'd2; end
      OP_ANDI: begin o_class = CL_IMM;   o_alu_op = ALU_AND; o_last_step = 3'd2; end
      OP_ORI:  begin o_class = CL_IMM;   o_alu_op = ALU_OR;  o_last_step = 3'd2; end
      // Address / target arithmetic is always an add
      OP_LDI:  begin o_class = CL_LDI;   o_alu_op = ALU_ADD; o_last_step = 3'd2; end
      OP_LD:   begin o_class = CL_LD;    o_alu_op = ALU_ADD; o_last_step = 3'd4; end
      OP_ST:   begin o_class = CL_ST;    o_alu_op = ALU_ADD; o_last_step = 3'd4; end
      OP_BR:   begin o_class = CL_BR;    o_alu_op = ALU_ADD; o_last_step = 3'd3; end
      OP_IN:   o_class = CL_IN;
      OP_OUT:  o_class = CL_OUT;
      OP_MFHI: o_class = CL_MFHI;
      OP_MFLO: o_class = CL_MFLO;
      OP_NOP:  o_class = CL_NOP;
      OP_HALT: o_class = CL_HALT;
      default: o_class = CL_ILL;
    endcase
  end

endmodule

// File: rtl/datapath_control_unit.sv
// Hardwired fetch/decode/execute sequencer for the single-bus datapath.
// Ports:
//   clock, clear        - rising-edge clock, synchronous active-high reset
//   IR, CON, Stop       - instruction register, branch condition, halt request
//   *out                - bus drivers (at most one active per cycle)
//   *in, IncPC          - register enables
//   Gra/Grb/Grc/Rin/Rout - register-file select controls
//   Read/Write/MD_read  - memory controls
//   alu_op/alu_en       - ALU control
//   Run, illegal        - status
//
// phase    | meaning
// ---------+-----------------------------------------------------------
// PH_RST   | reset hold, all outputs low, counts RESET_PC_HOLD cycles
// PH_FETCH | F0..F2: PC->MAR, memory->MDR, MDR->IR
// PH_EXEC  | E0..En: opcode-dependent execute steps
// PH_HALT  | parked, all outputs low, only clear leaves
module datapath_control_unit
  import cu_pkg::*;
#(
  parameter int RESET_PC_HOLD  = 1,
  parameter int EXEC_STEPS_MAX = 5
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        CON,
  input  logic        Stop,
  output logic        PCout,
  output logic        MDRout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        HIout,
  output logic        LOout,
  output logic        InPortout,
  output logic        Csignout,
  output logic        BAout,
  output logic        PCin,
  output logic        IRin,
  output logic        MARin,
  output logic        MDRin,
  output logic        Yin,
  output logic        Zlowin,
  output logic        Zhighin,
  output logic        HIin,
  output logic        LOin,
  output logic        Out_Portin,
  output logic        CONin,
  output logic        IncPC,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        Read,
  output logic        Write,
  output logic        MD_read,
  output logic [3:0]  alu_op,
  output logic        alu_en,
  output logic        Run,
  output logic        illegal
);

  localparam logic [2:0] STEP_LIMIT = 3'(EXEC_STEPS_MAX - 1);
  localparam logic [3:0] HOLD_INIT  = 4'(RESET_PC_HOLD);

  phase_t     r_phase;
  logic [2:0] r_step;
  logic [3:0] r_hold;
  logic       r_illegal;
  logic       r_stop_req;

  logic [3:0] w_class_raw;
  iclass_t    w_class;
  logic [3:0] w_alu_op;
  logic [2:0] w_last_step;
  logic       w_exec_done;
  logic       w_unused_ir;

  cu_decode u_decode (
    .i_opcode    (IR[31:27]),
    .o_class     (w_class_raw),
    .o_alu_op    (w_alu_op),
    .o_last_step (w_last_step)
  );

  assign w_class     = iclass_t'(w_class_raw);
  assign w_unused_ir = ^IR[26:0];
  // Step limit guards the counter even if a decode entry were wrong
  assign w_exec_done = (r_step >= w_last_step) || (r_step == STEP_LIMIT);

  // Stop is remembered until the instruction boundary so a short pulse
  // mid-instruction still halts once the current instruction completes.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_phase    <= PH_RST;
      r_step     <= 3'd0;
      r_hold     <= HOLD_INIT;
      r_illegal  <= 1'b0;
      r_stop_req <= 1'b0;
    end else begin
      case (r_phase)
        PH_RST: begin
          if (r_hold == 4'd0) begin
            r_phase <= PH_FETCH;
            r_step  <= 3'd0;
          end else begin
            r_hold <= r_hold - 4'd1;
          end
        end
        PH_FETCH: begin
          if (Stop) r_stop_req <= 1'b1;
          if (r_step == FETCH_LAST) begin
            r_phase <= PH_EXEC;
            r_step  <= 3'd0;
          end else begin
            r_step <= r_step + 3'd1;
          end
        end
        PH_EXEC: begin
          if (w_class == CL_ILL) begin
            r_illegal  <= 1'b1;
            r_phase    <= PH_HALT;
            r_step     <= 3'd0;
            r_stop_req <= 1'b0;
          end else if (w_class == CL_HALT) begin
            r_phase    <= PH_HALT;
            r_step     <= 3'd0;
            r_stop_req <= 1'b0;
          end else if (w_exec_done) begin
            r_step     <= 3'd0;
            r_stop_req <= 1'b0;
            r_phase    <= (Stop || r_stop_req) ? PH_HALT : PH_FETCH;
          end else begin
            if (Stop) r_stop_req <= 1'b1;
            r_step <= r_step + 3'd1;
          end
        end
        default: begin
          r_phase <= PH_HALT;
        end
      endcase
    end
  end

  assign Run     = (r_phase == PH_FETCH) || (r_phase == PH_EXEC);
  assign illegal = r_illegal;

  always_comb begin
    PCout = 1'b0; MDRout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0;
    HIout = 1'b0; LOout = 1'b0; InPortout = 1'b0; Csignout = 1'b0;
    BAout = 1'b0;
    PCin = 1'b0; IRin = 1'b0; MARin = 1'b0; MDRin = 1'b0; Yin = 1'b0;
    Zlowin = 1'b0; Zhighin = 1'b0; HIin = 1'b0; LOin = 1'b0;
    Out_Portin = 1'b0; CONin = 1'b0; IncPC = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
    Read = 1'b0; Write = 1'b0; MD_read = 1'b0;
    alu_op = ALU_NONE; alu_en = 1'b0;

    if (r_phase == PH_FETCH) begin
      case (r_step)
        3'd0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
        3'd1: begin Read = 1'b1; MD_read = 1'b1; MDRin = 1'b1; end
        3'd2: begin MDRout = 1'b1; IRin = 1'b1; end
        default: ;
      endcase
    end else if (r_phase == PH_EXEC) begin
      case (w_class)
        CL_RTYPE, CL_IMM: begin
          case (r_step)
            3'd0: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            3'd1: begin
              if (w_class == CL_IMM) begin
                Csignout = 1'b1;
              end else begin
                Grc  = 1'b1;
                Rout = 1'b1;
              end
              alu_en  = 1'b1;
              alu_op  = w_alu_op;
              Zlowin  = 1'b1;
              Zhighin = 1'b1;
            end
            3'd2: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            default: ;
          endcase
        end
        CL_LDI, CL_LD, CL_ST: begin
          case (r_step)
            3'd0: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
            3'd1: begin
              Csignout = 1'b1;
              alu_en   = 1'b1;
              alu_op   = w_alu_op;
              Zlowin   = 1'b1;
            end
            3'd2: begin
              Zlowout = 1'b1;
              if (w_class == CL_LDI) begin
                Gra = 1'b1;
                Rin = 1'b1;
              end else begin
                MARin = 1'b1;
              end
            end
            3'd3: begin
              MDRin = 1'b1;
              if (w_class == CL_LD) begin
                Read    = 1'b1;
                MD_read = 1'b1;
              end else if (w_class == CL_ST) begin
                Gra  = 1'b1;
                Rout = 1'b1;
              end
            end
            3'd4: begin
              MDRout = 1'b1;
              if (w_class == CL_LD) begin
                Gra = 1'b1;
                Rin = 1'b1;
              end else if (w_class == CL_ST) begin
                Write = 1'b1;
              end
            end
            default: ;
          endcase
        end
        CL_BR: begin
          case (r_step)
            3'd0: begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
            3'd1: begin PCout = 1'b1; Yin = 1'b1; end
            3'd2: begin
              Csignout = 1'b1;
              alu_en   = 1'b1;
              alu_op   = w_alu_op;
              Zlowin   = 1'b1;
            end
            3'd3: begin
              // Not-taken branch spends this step idle to keep timing fixed
              if (CON) begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
              end
            end
            default: ;
          endcase
        end
        CL_IN: begin
          if (r_step == 3'd0) begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        end
        CL_OUT: begin
          if (r_step == 3'd0) begin Gra = 1'b1; Rout = 1'b1; Out_Portin = 1'b1; end
        end
        CL_MFHI: begin
          if (r_step == 3'd0) begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        end
        CL_MFLO: begin
          if (r_step == 3'd0) begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_control_unit.sv
module tb_datapath_control_unit;

  logic        clock;
  logic        clear;
  logic [31:0] IR;
  logic        CON;
  logic        Stop;
  logic PCout, MDRout, Zhighout, Zlowout, HIout, LOout, InPortout, Csignout, BAout;
  logic PCin, IRin, MARin, MDRin, Yin, Zlowin, Zhighin, HIin, LOin, Out_Portin, CONin, IncPC;
  logic Gra, Grb, Grc, Rin, Rout;
  logic Read, Write, MD_read;
  logic [3:0] alu_op;
  logic alu_en, Run, illegal;

  datapath_control_unit dut (
    .clock(clock), .clear(clear), .IR(IR), .CON(CON), .Stop(Stop),
    .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Csignout(Csignout),
    .BAout(BAout), .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin),
    .Yin(Yin), .Zlowin(Zlowin), .Zhighin(Zhighin), .HIin(HIin), .LOin(LOin),
    .Out_Portin(Out_Portin), .CONin(CONin), .IncPC(IncPC), .Gra(Gra), .Grb(Grb),
    .Grc(Grc), .Rin(Rin), .Rout(Rout), .Read(Read), .Write(Write),
    .MD_read(MD_read), .alu_op(alu_op), .alu_en(alu_en), .Run(Run),
    .illegal(illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Observed control word: {Run, alu_op, alu_en, memory, selects, enables, drivers}
  logic [34:0] w_obs;
  assign w_obs = {Run, alu_op, alu_en, MD_read, Write, Read, Rout, Rin, Grc, Grb, Gra,
                  IncPC, CONin, Out_Portin, LOin, HIin, Zhighin, Zlowin, Yin, MDRin,
                  MARin, IRin, PCin, BAout, Csignout, InPortout, LOout, HIout, Zlowout,
                  Zhighout, MDRout, PCout};

  localparam logic [34:0] B_PCOUT   = 35'd1 << 0;
  localparam logic [34:0] B_MDROUT  = 35'd1 << 1;
  localparam logic [34:0] B_ZLOWOUT = 35'd1 << 3;
  localparam logic [34:0] B_HIOUT   = 35'd1 << 4;
  localparam logic [34:0] B_LOOUT   = 35'd1 << 5;
  localparam logic [34:0] B_INPORT  = 35'd1 << 6;
  localparam logic [34:0] B_CSIGN   = 35'd1 << 7;
  localparam logic [34:0] B_BAOUT   = 35'd1 << 8;
  localparam logic [34:0] B_PCIN    = 35'd1 << 9;
  localparam logic [34:0] B_IRIN    = 35'd1 << 10;
  localparam logic [34:0] B_MARIN   = 35'd1 << 11;
  localparam logic [34:0] B_MDRIN   = 35'd1 << 12;
  localparam logic [34:0] B_YIN     = 35'd1 << 13;
  localparam logic [34:0] B_ZLOWIN  = 35'd1 << 14;
  localparam logic [34:0] B_ZHIGHIN = 35'd1 << 15;
  localparam logic [34:0] B_OUTPIN  = 35'd1 << 18;
  localparam logic [34:0] B_CONIN   = 35'd1 << 19;
  localparam logic [34:0] B_INCPC   = 35'd1 << 20;
  localparam logic [34:0] B_GRA     = 35'd1 << 21;
  localparam logic [34:0] B_GRB     = 35'd1 << 22;
  localparam logic [34:0] B_GRC     = 35'd1 << 23;
  localparam logic [34:0] B_RIN     = 35'd1 << 24;
  localparam logic [34:0] B_ROUT    = 35'd1 << 25;
  localparam logic [34:0] B_READ    = 35'd1 << 26;
  localparam logic [34:0] B_WRITE   = 35'd1 << 27;
  localparam logic [34:0] B_MDREAD  = 35'd1 << 28;
  localparam logic [34:0] B_ALUEN   = 35'd1 << 29;
  localparam logic [34:0] B_RUN     = 35'd1 << 34;

  localparam logic [3:0] A_ADD = 4'b0100;
  localparam logic [3:0] A_SUB = 4'b0101;
  localparam logic [3:0] A_AND = 4'b0010;
  localparam logic [3:0] A_OR  = 4'b0011;

  int n_total = 0;
  int n_bad   = 0;
  logic [34:0] sb[$];

  task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%h want=%h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [34:0] alu(input logic [3:0] op);
    logic [34:0] w;
    w = {31'd0, op} << 30;
    return w | B_ALUEN;
  endfunction

  // Expected per-cycle control words for one instruction, written from the
  // step tables directly.
  task automatic push_instr(input logic [4:0] op, input logic con);
    logic [34:0] R;
    R = B_RUN;
    sb.push_back(R | B_PCOUT | B_MARIN | B_INCPC);
    sb.push_back(R | B_READ | B_MDREAD | B_MDRIN);
    sb.push_back(R | B_MDROUT | B_IRIN);
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
        sb.push_back(R | B_GRB | B_ROUT | B_YIN);
        sb.push_back(R | B_GRC | B_ROUT | B_ZLOWIN | B_ZHIGHIN |
                     alu(op == 5'b00011 ? A_ADD : op == 5'b00100 ? A_SUB :
                         op == 5'b00101 ? A_AND : A_OR));
        sb.push_back(R | B_ZLOWOUT | B_GRA | B_RIN);
      end
      5'b01100, 5'b01101, 5'b01110: begin
        sb.push_back(R | B_GRB | B_ROUT | B_YIN);
        sb.push_back(R | B_CSIGN | B_ZLOWIN | B_ZHIGHIN |
                     alu(op == 5'b01100 ? A_ADD : op == 5'b01101 ? A_AND : A_OR));
        sb.push_back(R | B_ZLOWOUT | B_GRA | B_RIN);
      end
      5'b00001: begin
        sb.push_back(R | B_GRB | B_BAOUT | B_YIN);
        sb.push_back(R | B_CSIGN | B_ZLOWIN | alu(A_ADD));
        sb.push_back(R | B_ZLOWOUT | B_GRA | B_RIN);
      end
      5'b00000, 5'b00010: begin
        sb.push_back(R | B_GRB | B_BAOUT | B_YIN);
        sb.push_back(R | B_CSIGN | B_ZLOWIN | alu(A_ADD));
        sb.push_back(R | B_ZLOWOUT | B_MARIN);
        if (op == 5'b00000) begin
          sb.push_back(R | B_READ | B_MDREAD | B_MDRIN);
          sb.push_back(R | B_MDROUT | B_GRA | B_RIN);
        end else begin
          sb.push_back(R | B_GRA | B_ROUT | B_MDRIN);
          sb.push_back(R | B_MDROUT | B_WRITE);
        end
      end
      5'b10010: begin
        sb.push_back(R | B_GRA | B_ROUT | B_CONIN);
        sb.push_back(R | B_PCOUT | B_YIN);
        sb.push_back(R | B_CSIGN | B_ZLOWIN | alu(A_ADD));
        sb.push_back(con ? (R | B_ZLOWOUT | B_PCIN) : R);
      end
      5'b10110: sb.push_back(R | B_INPORT | B_GRA | B_RIN);
      5'b10111: sb.push_back(R | B_GRA | B_ROUT | B_OUTPIN);
      5'b11000: sb.push_back(R | B_HIOUT | B_GRA | B_RIN);
      5'b11001: sb.push_back(R | B_LOOUT | B_GRA | B_RIN);
      default:  sb.push_back(R);   // nop, halt, undefined: one idle E0
    endcase
  endtask

  // Drives one instruction starting at its F0 cycle and checks every cycle.
  task automatic do_instr(input logic [31:0] ir, input logic con, input int stop_k,
                          input string tag);
    int k;
    logic [4:0] op;
    op = ir[31:27];
    push_instr(op, con);
    k = 0;
    while (sb.size() > 0 && k < 16) begin
      @(negedge clock);
      chk(tag, w_obs, sb.pop_front());
      if (k == 0) begin
        IR  = ir;
        CON = con;
      end
      if (k == stop_k) Stop = 1'b1;
      if (k == stop_k + 1) Stop = 1'b0;
      k++;
    end
    if (sb.size() != 0) begin
      chk({tag, "_budget"}, 35'd1, 35'd0);
      sb.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    clear = 1'b1;
    IR    = 32'h0;
    CON   = 1'b0;
    Stop  = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("clr_word", w_obs, 35'd0);
      chk("clr_ill", {34'd0, illegal}, 35'd0);
    end
    clear = 1'b0;
    @(negedge clock);
    chk("rst_hold", w_obs, 35'd0);

    do_instr(32'h1989_0000, 1'b0, -1, "add");
    do_instr({5'b00100, 27'h0123456}, 1'b0, -1, "sub");
    do_instr({5'b00101, 27'h0}, 1'b0, -1, "and");
    do_instr({5'b00110, 27'h7}, 1'b0, -1, "or");
    do_instr({5'b01100, 27'h15}, 1'b0, -1, "addi");
    do_instr({5'b01101, 27'h0}, 1'b0, -1, "andi");
    do_instr({5'b01110, 27'h3}, 1'b0, -1, "ori");
    do_instr({5'b00001, 27'h42}, 1'b0, -1, "ldi");
    do_instr({5'b00000, 27'h99}, 1'b0, -1, "ld");
    do_instr({5'b00010, 27'h55}, 1'b0, -1, "st");
    do_instr({5'b10010, 27'h10}, 1'b0, -1, "br_nt");
    do_instr({5'b10010, 27'h10}, 1'b1, -1, "br_t");
    do_instr({5'b10110, 27'h0}, 1'b0, -1, "in");
    do_instr({5'b10111, 27'h0}, 1'b0, -1, "out");
    do_instr({5'b11000, 27'h0}, 1'b0, -1, "mfhi");
    do_instr({5'b11001, 27'h0}, 1'b0, -1, "mflo");
    do_instr({5'b11010, 27'h0}, 1'b0, -1, "nop");

    // Stop pulsed during E1 (cycle index 4): add finishes, then halt
    do_instr(32'h1989_0000, 1'b0, 4, "add_stop");
    repeat (20) begin
      @(negedge clock);
      chk("halt_stop", w_obs, 35'd0);
    end

    // Undefined opcode
    clear = 1'b1;
    @(negedge clock);
    chk("clr2_word", w_obs, 35'd0);
    clear = 1'b0;
    @(negedge clock);
    chk("rst2_hold", w_obs, 35'd0);
    do_instr(32'hF800_0000, 1'b0, -1, "illop");
    repeat (3) begin
      @(negedge clock);
      chk("ill_halt", w_obs, 35'd0);
      chk("ill_flag", {34'd0, illegal}, 35'd1);
    end

    // clear recovers from illegal halt
    clear = 1'b1;
    @(negedge clock);
    chk("clr3_ill", {34'd0, illegal}, 35'd0);
    chk("clr3_word", w_obs, 35'd0);
    clear = 1'b0;
    @(negedge clock);
    chk("rst3_hold", w_obs, 35'd0);
    do_instr({5'b11010, 27'h0}, 1'b0, -1, "nop2");
    do_instr({5'b11011, 27'h0}, 1'b0, -1, "halt");
    repeat (3) begin
      @(negedge clock);
      chk("halt_op", w_obs, 35'd0);
      chk("halt_ill", {34'd0, illegal}, 35'd0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
